// File: rtl/fft_pkg.sv
// Shared constants, complex-word type and fixed-point helper functions for the
// 32-point FFT datapath (butterflies, twiddle ROM wrappers).
package fft_pkg;

  localparam int FFT_N   = 32;
  localparam int DATA_W  = 16;
  localparam int TW_FRAC = 14;
  localparam int TAG_W   = 5;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  // Largest / smallest value of a w-bit signed word.
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  // Half an LSB after dropping frac fractional bits (round-half-up offset).
  function automatic longint round_half(input int frac);
    return (frac > 0) ? (longint'(1) << (frac - 1)) : longint'(0);
  endfunction

endpackage

// File: rtl/fft_dit_butterfly_if.sv
// Stream bundle of the radix-2 butterfly: input samples + twiddle, results,
// valid/ready handshakes on both sides and the sticky overflow flag.
interface fft_dit_butterfly_if
  import fft_pkg::*;
#(
  parameter int N = DATA_W
);

  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] a_r, a_i;
  logic signed [N-1:0] b_r, b_i;
  logic signed [N-1:0] w_r, w_i;
  logic [TAG_W-1:0]    in_tag;

  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] x_r, x_i;
  logic signed [N-1:0] y_r, y_i;
  logic [TAG_W-1:0]    out_tag;

  logic                ovf;
  logic                ovf_clr;

  modport slave (
    input  in_valid, a_r, a_i, b_r, b_i, w_r, w_i, in_tag, out_ready, ovf_clr,
    output in_ready, out_valid, x_r, x_i, y_r, y_i, out_tag, ovf
  );

  modport master (
    output in_valid, a_r, a_i, b_r, b_i, w_r, w_i, in_tag, out_ready, ovf_clr,
    input  in_ready, out_valid, x_r, x_i, y_r, y_i, out_tag, ovf
  );

endinterface

// File: rtl/fft_cmul_pipe.sv
// Three-stage complex multiply T = B*W with round-half-up back to the data
// scale; stages advance together on en so a caller can stall the whole pipe.
module fft_cmul_pipe
  import fft_pkg::*;
#(
  parameter int N       = DATA_W,
  parameter int TW_FRAC = fft_pkg::TW_FRAC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [N-1:0] b_r,
  input  logic signed [N-1:0] b_i,
  input  logic signed [N-1:0] w_r,
  input  logic signed [N-1:0] w_i,
  output logic signed [N+1:0] t_r,
  output logic signed [N+1:0] t_i
);

  localparam int PW = 2 * N;
  localparam int SW = 2 * N + 1;
  localparam logic signed [SW-1:0] RND = SW'(round_half(TW_FRAC));

  function automatic logic signed [PW-1:0] sx2(input logic signed [N-1:0] v);
    return {{N{v[N-1]}}, v};
  endfunction

  // S1: registered operands
  logic signed [N-1:0] b_r1, b_i1, w_r1, w_i1;
  // S2: full-precision partial products
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  // S3 combinational: sums, rounding offset
  logic signed [SW-1:0] s_r, s_i, rnd_r, rnd_i;

  // NOTE: sequential state is assigned with <= so every stage samples the
  // previous stage's old value at the same edge; = here would collapse stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_r1 <= '0;
      b_i1 <= '0;
      w_r1 <= '0;
      w_i1 <= '0;
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
      t_r  <= '0;
      t_i  <= '0;
    end else if (en) begin
      b_r1 <= b_r;
      b_i1 <= b_i;
      w_r1 <= w_r;
      w_i1 <= w_i;
      p_rr <= sx2(b_r1) * sx2(w_r1);
      p_ii <= sx2(b_i1) * sx2(w_i1);
      p_ri <= sx2(b_r1) * sx2(w_i1);
      p_ir <= sx2(b_i1) * sx2(w_r1);
      // Keeping bits [TW_FRAC+N+1:TW_FRAC] is the arithmetic shift by TW_FRAC.
      t_r  <= rnd_r[TW_FRAC+N+1:TW_FRAC];
      t_i  <= rnd_i[TW_FRAC+N+1:TW_FRAC];
    end
  end

  // NOTE: every always_comb output is assigned on every path, so no latch.
  always_comb begin
    s_r   = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
    s_i   = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
    rnd_r = s_r + RND;
    rnd_i = s_i + RND;
  end

  // Dropped fraction and guard bits are intentionally discarded.
  logic unused_rnd_bits;
  assign unused_rnd_bits = ^{rnd_r, rnd_i};

endmodule

// File: rtl/fft_dit_butterfly.sv
// Radix-2 DIT butterfly X = A + B*W, Y = A - B*W: four-stage pipeline with
// rounding, optional /2 scaling, saturation and stall-all valid/ready flow.
module fft_dit_butterfly
  import fft_pkg::*;
#(
  parameter int N         = DATA_W,
  parameter int TW_FRAC   = fft_pkg::TW_FRAC,
  parameter int OUT_SHIFT = 0
) (
  input logic                 clk,
  input logic                 rst,
  fft_dit_butterfly_if.slave  bus
);

  localparam int XW = N + 3;
  localparam logic signed [XW-1:0] SMAX = XW'(sat_max(N));
  localparam logic signed [XW-1:0] SMIN = XW'(sat_min(N));
  localparam logic signed [XW-1:0] XONE = XW'(1);

  // Single advance enable: the whole pipe moves or the whole pipe holds.
  logic en;
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // Valid bits of S1..S3 and the A/tag delay line alongside the multiplier.
  logic [2:0]          vld;
  logic signed [N-1:0] a_r_d [3];
  logic signed [N-1:0] a_i_d [3];
  logic [TAG_W-1:0]    tag_d [3];

  // NOTE: the delay arrays are small register banks, not RAM, so they are
  // cleared in the reset branch like every other data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < 3; i++) begin
        a_r_d[i] <= '0;
        a_i_d[i] <= '0;
        tag_d[i] <= '0;
      end
    end else if (en) begin
      vld      <= {vld[1:0], bus.in_valid};
      a_r_d[0] <= bus.a_r;
      a_i_d[0] <= bus.a_i;
      tag_d[0] <= bus.in_tag;
      for (int i = 1; i < 3; i++) begin
        a_r_d[i] <= a_r_d[i-1];
        a_i_d[i] <= a_i_d[i-1];
        tag_d[i] <= tag_d[i-1];
      end
    end
  end

  logic signed [N+1:0] t_r, t_i;

  fft_cmul_pipe #(
    .N       (N),
    .TW_FRAC (TW_FRAC)
  ) u_cmul (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .b_r (bus.b_r),
    .b_i (bus.b_i),
    .w_r (bus.w_r),
    .w_i (bus.w_i),
    .t_r (t_r),
    .t_i (t_i)
  );

  // Returns {saturated, value}.
  function automatic logic [N:0] saturate(input logic signed [XW-1:0] v);
    logic [N:0] r;
    if (v > SMAX)      r = {1'b1, SMAX[N-1:0]};
    else if (v < SMIN) r = {1'b1, SMIN[N-1:0]};
    else               r = {1'b0, v[N-1:0]};
    return r;
  endfunction

  function automatic logic signed [XW-1:0] scale(input logic signed [XW-1:0] v);
    return (OUT_SHIFT != 0) ? ((v + XONE) >>> 1) : v;
  endfunction

  // S4 combinational: index 0..3 = x_r, x_i, y_r, y_i
  logic signed [XW-1:0] ext_a_r, ext_a_i, ext_t_r, ext_t_i;
  logic signed [XW-1:0] sum [4];
  logic [N:0]           res [4];
  logic                 sat_any;

  always_comb begin
    ext_a_r = {{3{a_r_d[2][N-1]}}, a_r_d[2]};
    ext_a_i = {{3{a_i_d[2][N-1]}}, a_i_d[2]};
    ext_t_r = {t_r[N+1], t_r};
    ext_t_i = {t_i[N+1], t_i};
    sum[0]  = scale(ext_a_r + ext_t_r);
    sum[1]  = scale(ext_a_i + ext_t_i);
    sum[2]  = scale(ext_a_r - ext_t_r);
    sum[3]  = scale(ext_a_i - ext_t_i);
    for (int i = 0; i < 4; i++) res[i] = saturate(sum[i]);
    sat_any = res[0][N] | res[1][N] | res[2][N] | res[3][N];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.x_r       <= '0;
      bus.x_i       <= '0;
      bus.y_r       <= '0;
      bus.y_i       <= '0;
      bus.out_tag   <= '0;
    end else if (en) begin
      bus.out_valid <= vld[2];
      bus.x_r       <= res[0][N-1:0];
      bus.x_i       <= res[1][N-1:0];
      bus.y_r       <= res[2][N-1:0];
      bus.y_i       <= res[3][N-1:0];
      bus.out_tag   <= tag_d[2];
    end
  end

  // Sticky overflow; a saturation in the same cycle as ovf_clr keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ovf <= 1'b0;
    end else if (en && vld[2] && sat_any) begin
      bus.ovf <= 1'b1;
    end else if (bus.ovf_clr) begin
      bus.ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_dit_butterfly.sv
// Self-checking bench for fft_dit_butterfly: directed cases from hand math,
// random streams with random backpressure against a plain-arithmetic model.
module tb_fft_dit_butterfly;
  import fft_pkg::*;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_dit_butterfly_if #(.N(N)) bus ();

  fft_dit_butterfly #(
    .N         (N),
    .TW_FRAC   (14),
    .OUT_SHIFT (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    int xr, xi, yr, yi;
    int tag;
    bit sat;
  } res_t;

  // Round-half-up of p / 2^14, straight from the arithmetic definition.
  function automatic longint rnd14(input longint p);
    return longint'($floor((real'(p) + 8192.0) / 16384.0));
  endfunction

  function automatic int clamp(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic res_t model(input int ar, ai, br, bi, wr, wi, tag);
    res_t   r;
    longint tr, ti;
    longint v [4];
    tr = rnd14(longint'(br) * wr - longint'(bi) * wi);
    ti = rnd14(longint'(br) * wi + longint'(bi) * wr);
    v[0] = ar + tr;
    v[1] = ai + ti;
    v[2] = ar - tr;
    v[3] = ai - ti;
    r.xr  = clamp(v[0]);
    r.xi  = clamp(v[1]);
    r.yr  = clamp(v[2]);
    r.yi  = clamp(v[3]);
    r.tag = tag;
    r.sat = 1'b0;
    for (int i = 0; i < 4; i++)
      if (v[i] > 32767 || v[i] < -32768) r.sat = 1'b1;
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  res_t exp_q [$];
  int   n_out = 0;
  bit   held  = 1'b0;
  int   h_xr, h_xi, h_yr, h_yi, h_tag;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(int'(bus.a_r), int'(bus.a_i), int'(bus.b_r),
                              int'(bus.b_i), int'(bus.w_r), int'(bus.w_i),
                              int'(bus.in_tag)));
      check("in_ready", longint'(bus.in_ready),
            longint'(!bus.out_valid || bus.out_ready));
      if (held) begin
        check("stall.valid", longint'(bus.out_valid), 1);
        check("stall.x_r", int'(bus.x_r), h_xr);
        check("stall.x_i", int'(bus.x_i), h_xi);
        check("stall.y_r", int'(bus.y_r), h_yr);
        check("stall.y_i", int'(bus.y_i), h_yi);
        check("stall.tag", int'(bus.out_tag), h_tag);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("out.x_r", int'(bus.x_r), e.xr);
          check("out.x_i", int'(bus.x_i), e.xi);
          check("out.y_r", int'(bus.y_r), e.yr);
          check("out.y_i", int'(bus.y_i), e.yi);
          check("out.tag", int'(bus.out_tag), e.tag);
        end
        n_out++;
      end
      held  = bus.out_valid && !bus.out_ready;
      h_xr  = int'(bus.x_r);
      h_xi  = int'(bus.x_i);
      h_yr  = int'(bus.y_r);
      h_yi  = int'(bus.y_i);
      h_tag = int'(bus.out_tag);
    end
  end

  // ---------------- drivers ----------------
  // Presents one transfer and returns #1 after the edge that accepted it;
  // in_valid is left high so callers can stream back-to-back.
  task automatic send(input int ar, ai, br, bi, wr, wi, tag);
    bit acc;
    int tries = 0;
    bus.in_valid = 1'b1;
    bus.a_r = 16'(ar);
    bus.a_i = 16'(ai);
    bus.b_r = 16'(br);
    bus.b_i = 16'(bi);
    bus.w_r = 16'(wr);
    bus.w_i = 16'(wi);
    bus.in_tag = 5'(tag);
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 200);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  // One isolated transfer: pins the model to hand-computed literals, then
  // checks latency and the DUT result against the same literals.
  task automatic directed(input string nm, input int ar, ai, br, bi, wr, wi, tag,
                          input int exr, exi, eyr, eyi);
    res_t m;
    int   lat;
    m = model(ar, ai, br, bi, wr, wi, tag);
    check({nm, ".model_xr"}, m.xr, exr);
    check({nm, ".model_xi"}, m.xi, exi);
    check({nm, ".model_yr"}, m.yr, eyr);
    check({nm, ".model_yi"}, m.yi, eyi);
    send(ar, ai, br, bi, wr, wi, tag);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, ".latency"}, lat, 4);
    check({nm, ".x_r"}, int'(bus.x_r), exr);
    check({nm, ".x_i"}, int'(bus.x_i), exi);
    check({nm, ".y_r"}, int'(bus.y_r), eyr);
    check({nm, ".y_i"}, int'(bus.y_i), eyi);
    check({nm, ".tag"}, int'(bus.out_tag), tag);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({nm, ".drained"}, exp_q.size(), 0);
  endtask

  bit rand_done = 1'b0;

  initial begin
    int out_before;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a_r = '0; bus.a_i = '0; bus.b_r = '0; bus.b_i = '0;
    bus.w_r = '0; bus.w_i = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    bus.ovf_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", bus.out_valid, 0);
    check("reset.in_ready", bus.in_ready, 1);
    check("reset.ovf", bus.ovf, 0);
    check("reset.x_r", int'(bus.x_r), 0);
    check("reset.y_i", int'(bus.y_i), 0);
    check("reset.tag", int'(bus.out_tag), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    directed("ident", 1000, -500, 200, 300, 16384, 0, 3, 1200, -200, 800, -800);
    directed("minus_j", 1000, -500, 200, 300, 0, -16384, 4, 1300, -700, 700, -300);
    directed("round_pos", 0, 0, 3, 0, 8192, 0, 5, 2, 0, -2, 0);
    directed("round_neg", 0, 0, -3, 0, 8192, 0, 6, -1, 0, 1, 0);
    directed("minus_one", 100, 200, 300, -400, -16384, 0, 8, -200, 600, 400, -200);
    check("ovf.before_sat", bus.ovf, 0);

    directed("sat", 32767, -32768, 1, 1, 16384, 0, 9, 32767, -32767, 32766, -32768);
    check("ovf.set", bus.ovf, 1);
    repeat (3) @(posedge clk);
    #1;
    check("ovf.sticky", bus.ovf, 1);
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
    check("ovf.cleared", bus.ovf, 0);

    // ovf_clr lands on the edge where a saturating result is registered.
    send(32767, -32768, 1, 1, 16384, 0, 10);
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
    check("set_wins.valid", bus.out_valid, 1);
    check("set_wins.ovf", bus.ovf, 1);
    @(posedge clk);
    #1;
    check("set_wins.ovf_hold", bus.ovf, 1);

    // 8 back-to-back transfers with a 3-cycle output stall in the middle.
    out_before = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 32768)) - 16384, int'($urandom_range(0, 32768)) - 16384, i);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        #1;
        check("bp.valid_at_stall", bus.out_valid, 1);
        check("bp.in_ready_low", bus.in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("bp");
    check("bp.count", n_out - out_before, 8);

    // Random traffic with random input gaps and random backpressure.
    out_before = n_out;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int wr, wi;
          bus.in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          wr = ($urandom_range(0, 7) == 0) ? -16384 : int'($urandom_range(0, 32768)) - 16384;
          wi = int'($urandom_range(0, 32768)) - 16384;
          send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
               wr, wi, i % 32);
        end
        bus.in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("rand");
    check("rand.count", n_out - out_before, 300);

    // Reset with three transactions in flight and the output stalled.
    check("rst_mid.ovf_before", bus.ovf, 1);
    for (int i = 0; i < 3; i++) send(32767, 32767, 30000, 30000, 16384, 0, 20 + i);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid.valid_before", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_mid.out_valid", bus.out_valid, 0);
    check("rst_mid.ovf", bus.ovf, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("rst_mid.no_stale", bus.out_valid, 0);
    end
    directed("after_rst", 1000, -500, 200, 300, 16384, 0, 7, 1200, -200, 800, -800);
    check("after_rst.ovf", bus.ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
